bru_notif_queue: RTL and testbench
==================================

# bru_notif_queue

Decoupling FIFO between the bru_pipeline branch notification output and the ROB branch notification input. It absorbs ROB backpressure so the BRU can keep resolving branches while the ROB is busy. The queue preserves BRU resolution order and can be flushed on a ROB-initiated restart. It sits directly downstream of bru_pipeline and upstream of the ROB.

## Interface

Parameters:
- DEPTH, 4: entry count; power of 2, minimum 2.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset; asynchronous, active-low
- enq_valid  input  1  notification present from bru_pipeline
- enq_ROB_index  input  LOG_ROB_ENTRIES  ROB index of the branch
- enq_is_mispredict  input  1  branch was mispredicted
- enq_is_taken  input  1  branch was resolved taken
- enq_is_out_of_range  input  1  target is outside the BTB range
- enq_updated_pred_info  input  BTB_PRED_INFO_WIDTH  updated prediction info
- enq_start_PC  input  32  branch PC
- enq_target_PC  input  32  resolved target PC
- enq_ready  output  1  to bru_pipeline branch_notif_ready
- deq_valid, deq_ROB_index, deq_is_mispredict, deq_is_taken, deq_is_out_of_range, deq_updated_pred_info, deq_start_PC, deq_target_PC  output  same widths as the enq_ fields  notification presented to the ROB
- deq_ready  input  1  ROB accepts the deq notification this cycle
- flush  input  1  ROB restart; discard all queued entries
- occupancy  output  log2(DEPTH)+1  current entry count

## Operation

- Pointers: enq_ptr and deq_ptr, each log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
- Enqueue fires when enq_valid and enq_ready: write the entry at enq_ptr, then increment enq_ptr.
- Dequeue fires when deq_valid and deq_ready: increment deq_ptr.
- enq_ready = !full, computed from registered state only. When full, enq_ready is low even if a dequeue fires the same cycle. There is no full-cycle pass-through.
- deq_valid = !empty. The deq_ fields come from the entry at deq_ptr. deq_ fields are don't-care while deq_valid = 0.
- Simultaneous enqueue and dequeue when neither full nor empty: both fire; occupancy is unchanged.
- flush:
  - Next cycle: enq_ptr = deq_ptr = 0 and occupancy = 0.
  - flush overrides any same-cycle enqueue or dequeue.
  - enq_ready stays combinationally !full during the flush cycle. An enqueue that fires in that cycle is dropped; the upstream BRU is flushed by the same restart.
- Entry storage has no reset requirement. Only the pointers are reset.
- Order is strict FIFO. There is no reordering and no mispredict prioritization.

## Timing

- Reset values: enq_ready = 1, deq_valid = 0, occupancy = 0. The deq_ fields read 0 after reset.
- Latency, without bypass: an entry enqueued in cycle N is presented on deq_valid in cycle N+1 at the earliest.
- Throughput: 1 enqueue and 1 dequeue per cycle.
- Boundaries:
  - Pointer wrap at DEPTH is seamless.
  - Full: enq_ready drops the cycle after the DEPTH-th entry is written.
  - Empty: deq_valid drops the cycle after the last entry is dequeued.
- Reset asserted mid-operation: all contents are lost immediately and outputs return to their reset values.

## Configuration

- BRU_NOTIF_QUEUE_BYPASS_EN defined:
  - When the queue is empty and enq_valid = 1, deq_valid = 1 combinationally and the deq_ fields equal the enq_ fields in the same cycle.
  - If deq_ready = 1 in that cycle, the entry is consumed and not written; pointers are unchanged.
  - If deq_ready = 0, the entry is written normally.
  - A flush in that cycle suppresses the bypass (deq_valid = 0).
- Not defined: no bypass; minimum latency is 1 cycle as described under Timing.

## Structure

- core_types_pkg gains a packed typedef branch_notif_t bundling ROB_index, is_mispredict, is_taken, is_out_of_range, updated_pred_info, start_PC and target_PC. The internal storage array uses this type.
- LOG_ROB_ENTRIES and BTB_PRED_INFO_WIDTH come from core_types_pkg.
- No sub-module. The flop array and pointer logic are inline.

## Test plan

- Reset, then enqueue one entry (ROB_index 5, target_PC 0x80001000, is_mispredict = 1) with deq_ready = 1 → deq_valid in cycle N+1 with matching fields, or in cycle N with BYPASS_EN; occupancy returns to 0.
- deq_ready held 0 while enqueuing 5 entries with DEPTH = 4 → the first 4 are accepted, enq_ready = 0 after the fourth, occupancy = 4; then deq_ready = 1 → ROB indices come out 4 entries in order, and enq_ready is high one cycle after the first dequeue.
- Queue at occupancy 2, enq_valid and deq_ready both high for 10 cycles → occupancy stays 2, all 10 entries out in order, and the pointers wrap at least twice.
- Queue at occupancy 3, flush together with enq_valid and deq_ready → next cycle occupancy = 0 and deq_valid = 0; the same-cycle enqueue is never presented.
- Queue full, nRST pulsed low mid-cycle → immediately deq_valid = 0, enq_ready = 1, occupancy = 0.
- BYPASS_EN, empty queue with enq_valid = 1 and deq_ready = 0 → deq_valid = 1 the same cycle; next cycle occupancy = 1 and the same entry is still presented.

Source files
------------

// File: rtl/core_types_pkg.sv
// Core-wide widths and the branch notification bundle passed from the BRU to the ROB.
package core_types_pkg;
  localparam int LOG_ROB_ENTRIES     = 6;
  localparam int BTB_PRED_INFO_WIDTH = 8;

  typedef struct packed {
    logic [LOG_ROB_ENTRIES-1:0]     ROB_index;
    logic                           is_mispredict;
    logic                           is_taken;
    logic                           is_out_of_range;
    logic [BTB_PRED_INFO_WIDTH-1:0] updated_pred_info;
    logic [31:0]                    start_PC;
    logic [31:0]                    target_PC;
  } branch_notif_t;
endpackage

// File: rtl/bru_notif_queue.sv
// FIFO decoupling bru_pipeline branch notifications from ROB backpressure, flushable on restart.
// Optional same-cycle empty-queue bypass under BRU_NOTIF_QUEUE_BYPASS_EN.
module bru_notif_queue
  import core_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           enq_valid,
  input  logic [LOG_ROB_ENTRIES-1:0]     enq_ROB_index,
  input  logic                           enq_is_mispredict,
  input  logic                           enq_is_taken,
  input  logic                           enq_is_out_of_range,
  input  logic [BTB_PRED_INFO_WIDTH-1:0] enq_updated_pred_info,
  input  logic [31:0]                    enq_start_PC,
  input  logic [31:0]                    enq_target_PC,
  output logic                           enq_ready,
  output logic                           deq_valid,
  output logic [LOG_ROB_ENTRIES-1:0]     deq_ROB_index,
  output logic                           deq_is_mispredict,
  output logic                           deq_is_taken,
  output logic                           deq_is_out_of_range,
  output logic [BTB_PRED_INFO_WIDTH-1:0] deq_updated_pred_info,
  output logic [31:0]                    deq_start_PC,
  output logic [31:0]                    deq_target_PC,
  input  logic                           deq_ready,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         occupancy
);
  localparam int IW = $clog2(DEPTH);

  branch_notif_t mem [DEPTH];
  branch_notif_t enq_bus, rd_bus, deq_bus;
  logic [IW:0]   enq_ptr, deq_ptr;
  logic          full, empty, bypass, enq_fire, deq_fire, wr_en, deq_inc;

  assign enq_bus = '{ROB_index: enq_ROB_index, is_mispredict: enq_is_mispredict,
                     is_taken: enq_is_taken, is_out_of_range: enq_is_out_of_range,
                     updated_pred_info: enq_updated_pred_info,
                     start_PC: enq_start_PC, target_PC: enq_target_PC};

  assign empty = (enq_ptr == deq_ptr);
  assign full  = (enq_ptr[IW] != deq_ptr[IW]) && (enq_ptr[IW-1:0] == deq_ptr[IW-1:0]);

`ifdef BRU_NOTIF_QUEUE_BYPASS_EN
  assign bypass = empty && enq_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign enq_ready = !full;
  assign deq_valid = !empty || bypass;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  // A bypassed entry that the ROB takes this cycle never touches storage or pointers.
  assign wr_en     = enq_fire && !(bypass && deq_ready);
  assign deq_inc   = deq_fire && !empty;
  assign occupancy = enq_ptr - deq_ptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
    end else if (flush) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
    end else begin
      if (wr_en)   enq_ptr <= enq_ptr + 1'b1;
      if (deq_inc) deq_ptr <= deq_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[enq_ptr[IW-1:0]] <= enq_bus;
  end

  // Gate with deq_valid so the fields read zero out of reset without resetting storage.
  assign rd_bus  = bypass ? enq_bus : mem[deq_ptr[IW-1:0]];
  assign deq_bus = deq_valid ? rd_bus : '0;

  assign deq_ROB_index         = deq_bus.ROB_index;
  assign deq_is_mispredict     = deq_bus.is_mispredict;
  assign deq_is_taken          = deq_bus.is_taken;
  assign deq_is_out_of_range   = deq_bus.is_out_of_range;
  assign deq_updated_pred_info = deq_bus.updated_pred_info;
  assign deq_start_PC          = deq_bus.start_PC;
  assign deq_target_PC         = deq_bus.target_PC;
endmodule

// File: tb/tb_bru_notif_queue.sv
// Directed bench for bru_notif_queue (DEPTH=4), covering both build options of the bypass macro.
module tb_bru_notif_queue;
  import core_types_pkg::*;

  logic                           CLK = 1'b0;
  logic                           nRST;
  logic                           enq_valid;
  logic [LOG_ROB_ENTRIES-1:0]     enq_ROB_index;
  logic                           enq_is_mispredict, enq_is_taken, enq_is_out_of_range;
  logic [BTB_PRED_INFO_WIDTH-1:0] enq_updated_pred_info;
  logic [31:0]                    enq_start_PC, enq_target_PC;
  logic                           enq_ready, deq_valid;
  logic [LOG_ROB_ENTRIES-1:0]     deq_ROB_index;
  logic                           deq_is_mispredict, deq_is_taken, deq_is_out_of_range;
  logic [BTB_PRED_INFO_WIDTH-1:0] deq_updated_pred_info;
  logic [31:0]                    deq_start_PC, deq_target_PC;
  logic                           deq_ready, flush;
  logic [2:0]                     occupancy;

  int total = 0;
  int bad   = 0;

  bru_notif_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .enq_valid(enq_valid), .enq_ROB_index(enq_ROB_index),
    .enq_is_mispredict(enq_is_mispredict), .enq_is_taken(enq_is_taken),
    .enq_is_out_of_range(enq_is_out_of_range), .enq_updated_pred_info(enq_updated_pred_info),
    .enq_start_PC(enq_start_PC), .enq_target_PC(enq_target_PC), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_ROB_index(deq_ROB_index),
    .deq_is_mispredict(deq_is_mispredict), .deq_is_taken(deq_is_taken),
    .deq_is_out_of_range(deq_is_out_of_range), .deq_updated_pred_info(deq_updated_pred_info),
    .deq_start_PC(deq_start_PC), .deq_target_PC(deq_target_PC),
    .deq_ready(deq_ready), .flush(flush), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive one notification; secondary fields are derived from the ROB index.
  task automatic drive(input logic v, input int rob, input logic [31:0] tgt, input logic mis);
    enq_valid             = v;
    enq_ROB_index         = LOG_ROB_ENTRIES'(rob);
    enq_is_mispredict     = mis;
    enq_is_taken          = rob[0];
    enq_is_out_of_range   = rob[1];
    enq_updated_pred_info = BTB_PRED_INFO_WIDTH'(rob + 8'h30);
    enq_start_PC          = 32'h0000_4000 + 32'(rob) * 4;
    enq_target_PC         = tgt;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; deq_ready = 1'b0;
    drive(1'b0, 0, 32'h0, 1'b0);
    #3;
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_deq_rob", 64'(deq_ROB_index), 64'd0);
    chk("rst_deq_tgt", 64'(deq_target_PC), 64'd0);
    step(); step();
    nRST = 1'b1;
    step();

    // Single entry with the ROB ready.
    drive(1'b1, 5, 32'h8000_1000, 1'b1);
    deq_ready = 1'b1;
    #1;
`ifdef BRU_NOTIF_QUEUE_BYPASS_EN
    chk("t1_byp_valid", 64'(deq_valid), 64'd1);
    chk("t1_byp_rob", 64'(deq_ROB_index), 64'd5);
    chk("t1_byp_tgt", 64'(deq_target_PC), 64'h8000_1000);
    chk("t1_byp_mis", 64'(deq_is_mispredict), 64'd1);
    step();
    enq_valid = 1'b0;
    #1;
`else
    chk("t1_lat_valid", 64'(deq_valid), 64'd0);
    step();
    enq_valid = 1'b0;
    #1;
    chk("t1_valid", 64'(deq_valid), 64'd1);
    chk("t1_rob", 64'(deq_ROB_index), 64'd5);
    chk("t1_tgt", 64'(deq_target_PC), 64'h8000_1000);
    chk("t1_mis", 64'(deq_is_mispredict), 64'd1);
    chk("t1_start", 64'(deq_start_PC), 64'h0000_4014);
    chk("t1_occ1", 64'(occupancy), 64'd1);
    step();
`endif
    chk("t1_occ0", 64'(occupancy), 64'd0);
    chk("t1_empty", 64'(deq_valid), 64'd0);

    // Fill past capacity with the ROB stalled, then drain in order.
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10 + i, 32'h9000_0000 + 32'(i), 1'b0);
      #1;
      chk($sformatf("t2_rdy%0d", i), 64'(enq_ready), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    enq_valid = 1'b0;
    #1;
    chk("t2_occ_full", 64'(occupancy), 64'd4);
    chk("t2_full_rdy", 64'(enq_ready), 64'd0);
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_v%0d", i), 64'(deq_valid), 64'd1);
      chk($sformatf("t2_rob%0d", i), 64'(deq_ROB_index), 64'(10 + i));
      chk($sformatf("t2_tgt%0d", i), 64'(deq_target_PC), 64'h9000_0000 + 64'(i));
      step();
      if (i == 0) chk("t2_rdy_back", 64'(enq_ready), 64'd1);
    end
    chk("t2_drained", 64'(deq_valid), 64'd0);
    chk("t2_occ0", 64'(occupancy), 64'd0);

    // Steady state at occupancy 2 with simultaneous enqueue and dequeue.
    deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 20 + i, 32'hA000_0000 + 32'(i), 1'b0);
      step();
    end
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 22 + i, 32'hA000_0000 + 32'(i + 2), i[0]);
      #1;
      chk($sformatf("t3_rob%0d", i), 64'(deq_ROB_index), 64'(20 + i));
      chk($sformatf("t3_occ%0d", i), 64'(occupancy), 64'd2);
      step();
    end
    enq_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      #1;
      chk($sformatf("t3_tail%0d", i), 64'(deq_ROB_index), 64'(20 + i));
      chk($sformatf("t3_tgt%0d", i), 64'(deq_target_PC), 64'hA000_0000 + 64'(i));
      step();
    end
    chk("t3_empty", 64'(deq_valid), 64'd0);

    // Flush at occupancy 3 alongside an enqueue and dequeue.
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 40 + i, 32'hB000_0000, 1'b0);
      step();
    end
    drive(1'b1, 43, 32'hB000_0043, 1'b1);
    deq_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("t4_flush_rdy", 64'(enq_ready), 64'd1);
    step();
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    chk("t4_occ", 64'(occupancy), 64'd0);
    chk("t4_valid", 64'(deq_valid), 64'd0);
    step();
    chk("t4_no_ghost", 64'(deq_valid), 64'd0);

    // Asynchronous reset while full.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 50 + i, 32'hC000_0000, 1'b0);
      step();
    end
    enq_valid = 1'b0;
    #1;
    chk("t5_pre_full", 64'(enq_ready), 64'd0);
    #2;
    nRST = 1'b0;
    #1;
    chk("t5_valid", 64'(deq_valid), 64'd0);
    chk("t5_rdy", 64'(enq_ready), 64'd1);
    chk("t5_occ", 64'(occupancy), 64'd0);
    step();
    nRST = 1'b1;
    step();

    // Empty queue, enqueue with the ROB stalled.
    drive(1'b1, 60, 32'hD000_0060, 1'b0);
    deq_ready = 1'b0;
    #1;
`ifdef BRU_NOTIF_QUEUE_BYPASS_EN
    chk("t6_byp_valid", 64'(deq_valid), 64'd1);
    chk("t6_byp_rob", 64'(deq_ROB_index), 64'd60);
`else
    chk("t6_valid0", 64'(deq_valid), 64'd0);
`endif
    step();
    enq_valid = 1'b0;
    #1;
    chk("t6_occ", 64'(occupancy), 64'd1);
    chk("t6_valid", 64'(deq_valid), 64'd1);
    chk("t6_rob", 64'(deq_ROB_index), 64'd60);
    chk("t6_tgt", 64'(deq_target_PC), 64'hD000_0060);

    // Flush on an empty queue with a pending enqueue presents nothing.
    deq_ready = 1'b1;
    step();
    drive(1'b1, 61, 32'hD000_0061, 1'b0);
    flush = 1'b1;
    #1;
    chk("t7_flush_nobyp", 64'(deq_valid), 64'd0);
    step();
    flush = 1'b0; enq_valid = 1'b0;
    #1;
    chk("t7_occ", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
